// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared types and constants for the RV32M multiply/divide unit.
// Optional feature macro used by the unit: MULDIV_FAST_MUL_EN.
package muldiv_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  // Instruction identification for the R-type M-extension group
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Architectural results for the divide corner cases
  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN       = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  // rs1 is read as two's complement for every op except the unsigned forms
  function automatic logic op_a_signed(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is unsigned for MULHSU in addition to the unsigned forms
  function automatic logic op_b_signed(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: issue and write-back handshake bundle of the multiply/divide unit.
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            busy;

  // Issue side / write-back side driver (register file and decode)
  modport master (
    output in_valid, funct3, op_a, op_b, rd_in, out_ready,
    input  in_ready, out_valid, result, rd_out, busy
  );

  // The execute unit itself
  modport slave (
    input  in_valid, funct3, op_a, op_b, rd_in, out_ready,
    output in_ready, out_valid, result, rd_out, busy
  );

endinterface

// File: rtl/muldiv_unit_div_step.sv
// muldiv_div_step: one combinational restoring-division iteration.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits, producing one quotient bit.
module muldiv_div_step
  import muldiv_unit_pkg::*;
(
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            dividend_bit_i,
  output logic [XLEN:0]   rem_o,
  output logic            q_bit_o
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  // Trial subtraction; a non-negative difference means the divisor fits
  always_comb begin
    shifted = {rem_i, dividend_bit_i};
    diff    = shifted - {2'b00, divisor_i};
    q_bit_o = ~diff[XLEN+1];
    rem_o   = q_bit_o ? diff[XLEN:0] : shifted[XLEN:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execute unit.
// Works on operand magnitudes (shift-add multiply, restoring divide, one bit
// per cycle) and restores signs in a final FIX cycle.
// Optional macro MULDIV_FAST_MUL_EN: multiplies finish in one cycle through a
// full-width multiplier; divides always use the iterative path.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  muldiv_state_e         state_q, state_d;
  muldiv_op_e            op_q;
  logic [4:0]            rd_q;
  logic                  sign_a_q, sign_b_q;
  logic [XLEN-1:0]       opnd_q;     // multiplicand |a| or divisor |b|
  logic [2*XLEN-1:0]     acc_q;      // product / {unused, quotient-dividend}
  logic [XLEN:0]         rem_q;
  logic [CNT_W-1:0]      count_q;
  logic [XLEN-1:0]       result_q;

  // Incoming-op decode
  muldiv_op_e            in_op;
  logic                  in_is_div;
  logic                  in_neg_a, in_neg_b;
  logic [XLEN-1:0]       abs_a, abs_b;
  logic                  div_zero, div_ovf, special_hit, fast_hit;
  logic [XLEN-1:0]       special_res;
  logic                  accept;

  // Iteration datapath
  logic [XLEN:0]         mul_sum;
  logic [XLEN:0]         div_rem;
  logic                  div_qbit;

  // Sign-corrected results
  logic [2*XLEN-1:0]     prod_fix;
  logic [XLEN-1:0]       quot_fix, rem_fix, fix_res;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  logic [XLEN-1:0]          fast_res;
`endif

  assign accept = bus.in_valid && (state_q == ST_IDLE);

  // Decode the presented op: operand magnitudes and corner-case results
  always_comb begin
    in_op       = muldiv_op_e'(bus.funct3);
    in_is_div   = bus.funct3[2];
    in_neg_a    = op_a_signed(in_op) && bus.op_a[XLEN-1];
    in_neg_b    = op_b_signed(in_op) && bus.op_b[XLEN-1];
    abs_a       = in_neg_a ? -bus.op_a : bus.op_a;
    abs_b       = in_neg_b ? -bus.op_b : bus.op_b;
    div_zero    = in_is_div && (bus.op_b == '0);
    div_ovf     = ((in_op == OP_DIV) || (in_op == OP_REM)) &&
                  (bus.op_a == INT_MIN) && (bus.op_b == '1);
    special_hit = div_zero || div_ovf;
    // funct3[1] separates remainder ops from quotient ops among divides
    if (div_zero) special_res = bus.funct3[1] ? bus.op_a : DIV_BY_ZERO_Q;
    else          special_res = bus.funct3[1] ? '0 : INT_MIN;
`ifdef MULDIV_FAST_MUL_EN
    fast_hit  = !in_is_div;
    fast_a    = {{XLEN{op_a_signed(in_op) && bus.op_a[XLEN-1]}}, bus.op_a};
    fast_b    = {{XLEN{op_b_signed(in_op) && bus.op_b[XLEN-1]}}, bus.op_b};
    fast_prod = fast_a * fast_b;
    fast_res  = (in_op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
    fast_hit  = 1'b0;
`endif
  end

  // Shift-add step: add multiplicand into the high half when the multiplier LSB is set
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  end

  muldiv_div_step u_div_step (
    .rem_i          (rem_q),
    .divisor_i      (opnd_q),
    .dividend_bit_i (acc_q[XLEN-1]),
    .rem_o          (div_rem),
    .q_bit_o        (div_qbit)
  );

  // Sign correction of the magnitude results and final result selection
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = sign_a_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    case (op_q)
      OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quot_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid) state_d = (special_hit || fast_hit) ? ST_DONE : ST_CALC;
      ST_CALC: if (count_q == CNT_LAST) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake and busy flags decoded from state
  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.busy      = (state_q != ST_IDLE);
    bus.out_valid = (state_q == ST_DONE);
  end

  assign bus.result = result_q;
  assign bus.rd_out = rd_q;

  // Datapath registers: operand capture, per-cycle iteration, result latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= OP_MUL;
      rd_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q     <= in_op;
            rd_q     <= bus.rd_in;
            sign_a_q <= in_neg_a;
            sign_b_q <= in_neg_b;
            count_q  <= '0;
            rem_q    <= '0;
            // Multiply: |a| is the addend, |b| shifts out of the low half.
            // Divide: |b| is the divisor, |a| shifts out as quotient shifts in.
            opnd_q   <= in_is_div ? abs_b : abs_a;
            acc_q    <= {{XLEN{1'b0}}, (in_is_div ? abs_a : abs_b)};
            if (special_hit) result_q <= special_res;
`ifdef MULDIV_FAST_MUL_EN
            else if (fast_hit) result_q <= fast_res;
`endif
          end
        end
        ST_CALC: begin
          count_q <= count_q + 1'b1;
          if (op_q[2]) begin
            acc_q <= {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_qbit};
            rem_q <= div_rem;
          end else begin
            acc_q <= {mul_sum, acc_q[XLEN-1:1]};
          end
        end
        ST_FIX: result_q <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;
  localparam int MAX_WAIT = 100;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Issue one op and wait for its result; latency counts the accept edge as 1.
  // Caller sits 1 time unit after a rising edge, unit idle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res,
                        output logic [4:0] rdo, output int lat);
    bus.funct3   = f3;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.rd_in    = rd;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    rdo = bus.rd_out;
    $display("op f3=%0d a=%h b=%h rd=%0d -> result=%h rd_out=%0d latency=%0d",
             f3, a, b, rd, res, rdo, lat);
    // handoff edge (out_ready held high by caller)
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.funct3     = 3'd0;
    bus.op_a       = '0;
    bus.op_b       = '0;
    bus.rd_in      = '0;
    bus.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 0", bus.result); end
    n_vec++; if (bus.rd_out !== 5'd0) begin n_err++; $display("FAIL reset_rd_out got %0d want 0", bus.rd_out); end
    reset = 1'b0;
    @(posedge clk); #1;
    $display("reset applied and released");
  endtask

  task automatic test_mul();
    logic [31:0] r; logic [4:0] d; int l;
    run_op(3'd0, 32'd7, 32'd6, 5'd5, r, d, l);
    n_vec++; if (r !== 32'h2A) begin n_err++; $display("FAIL mul_7x6 got %h want 0000002a", r); end
    n_vec++; if (d !== 5'd5) begin n_err++; $display("FAIL mul_rd got %0d want 5", d); end
    n_vec++; if (l !== MUL_LAT) begin n_err++; $display("FAIL mul_latency got %0d want %0d", l, MUL_LAT); end
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 5'd6, r, d, l);
    n_vec++; if (r !== 32'hFFFF_FFF1) begin n_err++; $display("FAIL mul_neg got %h want fffffff1", r); end
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd7, r, d, l);
    n_vec++; if (r !== 32'h4000_0000) begin n_err++; $display("FAIL mulh got %h want 40000000", r); end
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, r, d, l);
    n_vec++; if (r !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mulhu got %h want fffffffe", r); end
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd9, r, d, l);
    n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mulhsu got %h want ffffffff", r); end
    n_vec++; if (d !== 5'd9) begin n_err++; $display("FAIL mulhsu_rd got %0d want 9", d); end
  endtask

  task automatic test_div();
    logic [31:0] r; logic [4:0] d; int l;
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, r, d, l);
    n_vec++; if (r !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_m7_2 got %h want fffffffd", r); end
    n_vec++; if (l !== DIV_LAT) begin n_err++; $display("FAIL div_latency got %0d want %0d", l, DIV_LAT); end
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, r, d, l);
    n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rem_m7_2 got %h want ffffffff", r); end
    run_op(3'd5, 32'd100, 32'd7, 5'd12, r, d, l);
    n_vec++; if (r !== 32'd14) begin n_err++; $display("FAIL divu_100_7 got %h want 0000000e", r); end
    run_op(3'd7, 32'd100, 32'd7, 5'd13, r, d, l);
    n_vec++; if (r !== 32'd2) begin n_err++; $display("FAIL remu_100_7 got %h want 00000002", r); end
    run_op(3'd4, 32'd7, 32'hFFFF_FFFE, 5'd14, r, d, l);
    n_vec++; if (r !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_7_m2 got %h want fffffffd", r); end
    run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd15, r, d, l);
    n_vec++; if (r !== 32'd1) begin n_err++; $display("FAIL rem_7_m2 got %h want 00000001", r); end
    n_vec++; if (d !== 5'd15) begin n_err++; $display("FAIL rem_rd got %0d want 15", d); end
  endtask

  task automatic test_special();
    logic [31:0] r; logic [4:0] d; int l;
    run_op(3'd5, 32'd5, 32'd0, 5'd16, r, d, l);
    n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divu_by0 got %h want ffffffff", r); end
    n_vec++; if (l !== 1) begin n_err++; $display("FAIL divu_by0_latency got %0d want 1", l); end
    run_op(3'd7, 32'd5, 32'd0, 5'd17, r, d, l);
    n_vec++; if (r !== 32'd5) begin n_err++; $display("FAIL remu_by0 got %h want 00000005", r); end
    n_vec++; if (l !== 1) begin n_err++; $display("FAIL remu_by0_latency got %0d want 1", l); end
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, r, d, l);
    n_vec++; if (r !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf got %h want 80000000", r); end
    n_vec++; if (l !== 1) begin n_err++; $display("FAIL div_ovf_latency got %0d want 1", l); end
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, r, d, l);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL rem_ovf got %h want 00000000", r); end
    n_vec++; if (d !== 5'd19) begin n_err++; $display("FAIL rem_ovf_rd got %0d want 19", d); end
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd20, r, d, l);
    n_vec++; if (r !== 32'hFFFF_FFF9) begin n_err++; $display("FAIL rem_by0_neg got %h want fffffff9", r); end
  endtask

  task automatic test_backpressure();
    logic [31:0] r; logic [4:0] d; int l;
    bus.out_ready = 1'b0;
    bus.funct3    = 3'd5;
    bus.op_a      = 32'd100;
    bus.op_b      = 32'd7;
    bus.rd_in     = 5'd9;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    l = 1;
    while (!bus.out_valid && l < MAX_WAIT) begin
      @(posedge clk); #1;
      l++;
    end
    n_vec++; if (l !== DIV_LAT) begin n_err++; $display("FAIL bp_latency got %0d want %0d", l, DIV_LAT); end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.funct3   = 3'd0;
        bus.op_a     = 32'd3;
        bus.op_b     = 32'd3;
        bus.rd_in    = 5'd1;
        bus.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n_vec++; if (bus.result !== 32'd14) begin n_err++; $display("FAIL bp_result[%0d] got %h want 0000000e", i, bus.result); end
      n_vec++; if (bus.rd_out !== 5'd9) begin n_err++; $display("FAIL bp_rd_out[%0d] got %0d want 9", i, bus.rd_out); end
      n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, bus.in_ready); end
      n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid[%0d] got %b want 1", i, bus.out_valid); end
    end
    $display("backpressure stall held 5 cycles, result=%h rd_out=%0d", bus.result, bus.rd_out);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_out_valid got %b want 0", bus.out_valid); end
    run_op(3'd0, 32'd2, 32'd4, 5'd2, r, d, l);
    n_vec++; if (r !== 32'd8) begin n_err++; $display("FAIL bp_next_op got %h want 00000008", r); end
    n_vec++; if (d !== 5'd2) begin n_err++; $display("FAIL bp_next_rd got %0d want 2", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; logic [4:0] d; int l;
    // run_op ends just after the handoff edge: in_ready must already be back
    run_op(3'd5, 32'd81, 32'd9, 5'd21, r, d, l);
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got %b want 1", bus.in_ready); end
    n_vec++; if (r !== 32'd9) begin n_err++; $display("FAIL b2b_first got %h want 00000009", r); end
    run_op(3'd7, 32'd82, 32'd9, 5'd22, r, d, l);
    n_vec++; if (r !== 32'd1) begin n_err++; $display("FAIL b2b_second got %h want 00000001", r); end
    n_vec++; if (l !== DIV_LAT) begin n_err++; $display("FAIL b2b_latency got %0d want %0d", l, DIV_LAT); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic [4:0] d; int l;
    int stale;
    bus.funct3   = 3'd4;
    bus.op_a     = 32'd1000;
    bus.op_b     = 32'd3;
    bus.rd_in    = 5'd23;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_out_valid got %b want 0", bus.out_valid); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready got %b want 1", bus.in_ready); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    $display("reset asserted mid-divide and released");
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) stale++;
    end
    n_vec++; if (stale !== 0) begin n_err++; $display("FAIL rst_mid_stale got %0d cycles want 0", stale); end
    run_op(3'd0, 32'd3, 32'd5, 5'd3, r, d, l);
    n_vec++; if (r !== 32'd15) begin n_err++; $display("FAIL rst_mid_mul got %h want 0000000f", r); end
    n_vec++; if (d !== 5'd3) begin n_err++; $display("FAIL rst_mid_rd got %0d want 3", d); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execute unit sitting directly downstream of the register file. It consumes the two read operands (data1, data2) plus the decoded funct3 and destination register of an R-type MUL/DIV instruction (opcode 0110011, funct7 0000001). It produces a 32-bit result and rd tag that feed the register file's write_data/rd write-back port. Operations are multi-cycle behind a valid/ready handshake on both sides.

## Interface
- XLEN, 32: operand/result width; iteration count.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/op valid.
- in_ready  output  1  unit can accept (high only in IDLE).
- funct3  input  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_a  input  XLEN  rs1 value (register-file data1).
- op_b  input  XLEN  rs2 value (register-file data2).
- rd_in  input  5  destination register tag.
- out_valid  output  1  result valid.
- out_ready  input  1  write-back accepts result.
- result  output  XLEN  write-back data.
- rd_out  output  5  destination tag of result.
- busy  output  1  high in any state except IDLE.

## Operation
- States: IDLE, CALC, FIX, DONE. Encodings are held in the shared package.
- IDLE: in_ready=1. On in_valid, latch funct3, rd_in and operand signs. Latch |op_a| and |op_b|; an operand is treated as signed per funct3 (MULHSU: a signed, b unsigned). Clear the iteration counter.
- Special cases, decided in IDLE and going IDLE->DONE directly:
  - DIV/DIVU/REM/REMU with op_b=0: quotient 0xFFFFFFFF, remainder = op_a.
  - DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Otherwise go IDLE->CALC.
- CALC, multiply: radix-2 shift-add. There is one partial-product step per cycle into a 2*XLEN accumulator.
- CALC, divide: restoring division. There is one quotient bit per cycle, remainder width XLEN+1.
- CALC exits to FIX after XLEN iterations (counter 0..XLEN-1, width clog2(XLEN)).
- FIX applies sign correction:
  - Product negated if the operand signs differ.
  - Quotient negated if the signs differ.
  - Remainder takes the sign of the dividend.
- FIX selects the result: low half for MUL, high half for MULH/MULHSU/MULHU, quotient or remainder for divides.
- DONE: out_valid=1; result and rd_out are held stable. On out_ready the unit goes to IDLE.
- in_valid outside IDLE is ignored; no queueing.
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, result 0, rd_out 0, counter 0.
- Asynchronous reset mid-operation aborts the operation. No stale out_valid appears after reset release.

## Timing
- Accept on the clk edge where in_valid and in_ready are both high.
- Iterative ops: out_valid rises XLEN+2 edges after accept (34 for XLEN=32).
- Special cases: out_valid rises 1 edge after accept.
- Result handoff happens on the edge where out_valid and out_ready are both high. in_ready rises on that same edge.
- Maximum throughput is one op per XLEN+3 cycles.
- out_ready tied high adds zero stall cycles.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - funct3 0-3 compute with a single-cycle 2*XLEN signed/unsigned multiplier in IDLE and go IDLE->DONE, giving out_valid 1 edge after accept.
  - Divides are unchanged.
- Undefined: all multiplies use the iterative CALC/FIX path.
- Results are bit-identical in both builds.

## Structure
- Shared package holds:
  - funct3 op encodings.
  - OPCODE_OP=7'b0110011 and FUNCT7_MULDIV=7'b0000001.
  - State encodings.
  - DIV_BY_ZERO_Q=32'hFFFFFFFF.
- One sub-module: muldiv_div_step, a combinational single restoring-division iteration. Inputs are remainder, divisor and the next dividend bit; outputs are the new remainder and the quotient bit.
- Multiply step, sign fix and FSM stay inline.

## Test plan
- MUL 7*6 with out_ready=1 -> result 42 (0x2A), rd_out = rd_in, out_valid exactly 34 edges after accept.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. Each has out_valid 1 edge after accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/rd_out stable, in_ready=0, an in_valid pulse is ignored. Raising out_ready gives IDLE next edge.
- Assert reset at CALC iteration 10 -> out_valid 0, in_ready 1, busy 0 immediately. After release, MUL 3*5 -> 15.
